// File: rtl/result_uart_tx_pkg.sv
// rtl/result_uart_tx_pkg.sv - shared state type and defaults for the result UART transmitter
package result_uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    STOP_BIT
  } uart_state_e;

  localparam logic [7:0] DEFAULT_HEADER       = 8'hA5;
  localparam int         DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 byte serialiser with valid/ready byte input and registered tx
module uart_tx_byte
  import result_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_tdata,
  input  logic       byte_tvalid,
  output logic       byte_tready,
  output logic       tx,
  output logic       frame_end
);

  localparam int             CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]  BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  uart_state_e   state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_q, tx_d;
  logic          wrap;

  assign wrap = (baud_q == BAUD_LAST);
  assign tx   = tx_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
    end
  end

  // tx_d is the line level of the state being entered, so tx stays a plain flop
  always_comb begin
    state_d     = state_q;
    baud_d      = wrap ? '0 : baud_q + 1'b1;
    bit_d       = bit_q;
    sh_d        = sh_q;
    tx_d        = tx_q;
    byte_tready = 1'b0;
    frame_end   = 1'b0;
    case (state_q)
      IDLE: begin
        byte_tready = 1'b1;
        baud_d      = '0;
        if (byte_tvalid) begin
          sh_d    = byte_tdata;
          state_d = START_BIT;
          tx_d    = 1'b0;
        end
      end
      START_BIT: begin
        if (wrap) begin
          state_d = DATA_BITS;
          bit_d   = '0;
          tx_d    = sh_q[0];
        end
      end
      DATA_BITS: begin
        if (wrap) begin
          if (bit_q == 4'd7) begin
            state_d = STOP_BIT;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 4'd1;
            sh_d  = sh_q >> 1;
            tx_d  = sh_q[1];
          end
        end
      end
      STOP_BIT: begin
        if (wrap) begin
          // Accepting here chains the next start bit with no idle gap
          byte_tready = 1'b1;
          if (byte_tvalid) begin
            sh_d    = byte_tdata;
            state_d = START_BIT;
            tx_d    = 1'b0;
          end else begin
            state_d   = IDLE;
            frame_end = 1'b1;
            tx_d      = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/result_uart_tx.sv
// rtl/result_uart_tx.sv - captures a result vector and sends it as a headed UART frame
module result_uart_tx
  import result_uart_tx_pkg::*;
#(
  parameter int         DATAWIDTH    = 8,
  parameter int         ELEMS        = 16,
  parameter int         CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter logic [7:0] HEADER       = DEFAULT_HEADER
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATAWIDTH*ELEMS-1:0] C_in,
  input  logic                       start,
  output logic                       tx,
  output logic                       busy,
  output logic                       done
);

  localparam int NBYTES = ELEMS * DATAWIDTH / 8;
  localparam int IW     = $clog2(NBYTES + 1);

  logic [DATAWIDTH*ELEMS-1:0] buf_q;
  logic [IW-1:0]              idx_q;
  logic [IW-1:0]              sel;
  logic                       active_q;
  logic                       done_q;
  logic                       more;
  logic [7:0]                 byte_tdata;
  logic                       byte_tvalid;
  logic                       byte_tready;
  logic                       frame_end;

  assign more = (idx_q != IW'(NBYTES));
  assign sel  = more ? idx_q : '0;
  assign busy = active_q;
  assign done = done_q;

  // Elements are packed LSB-first, so buffer byte k is frame payload byte k
  always_comb begin
    byte_tdata  = HEADER;
    byte_tvalid = start;
    if (active_q) begin
      byte_tdata  = 8'(buf_q >> {sel, 3'b000});
      byte_tvalid = more;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_q    <= '0;
      idx_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!active_q) begin
        if (start) begin
          buf_q    <= C_in;
          idx_q    <= '0;
          active_q <= 1'b1;
        end
      end else begin
        if (byte_tvalid && byte_tready) idx_q <= idx_q + 1'b1;
        if (frame_end) begin
          active_q <= 1'b0;
          done_q   <= 1'b1;
        end
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk        (clk),
    .rst        (rst),
    .byte_tdata (byte_tdata),
    .byte_tvalid(byte_tvalid),
    .byte_tready(byte_tready),
    .tx         (tx),
    .frame_end  (frame_end)
  );

endmodule

// File: doc/result_uart_tx.md
RESULT_UART_TX -- requirements
Module: result_uart_tx

Interface
REQ-001: Parameter DATAWIDTH, default 8, width in bits of one result element; SHALL be 8 or 16.
REQ-002: Parameter ELEMS, default 16, number of result elements on the input bus.
REQ-003: Parameter CLKS_PER_BIT, default 868, clk cycles per UART bit (115200 baud at 100 MHz); SHALL be at least 2.
REQ-004: Parameter HEADER, default 8'hA5, sync byte sent before every frame.
REQ-005: clk  input  1  single system clock; all state changes on its rising edge.
REQ-006: rst  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-007: C_in  input  DATAWIDTH*ELEMS  result matrix from the multiplier; element j is C_in[j*DATAWIDTH +: DATAWIDTH].
REQ-008: start  input  1  request to capture C_in and transmit one frame; sampled each clk edge.
REQ-009: tx  output  1  UART serial line, 8N1, idle high.
REQ-010: busy  output  1  high from the cycle after start is accepted until the frame completes.
REQ-011: done  output  1  one-cycle pulse when the last stop bit ends.

Function
REQ-012: States: IDLE, START_BIT, DATA_BITS, STOP_BIT; no other state is reachable.
REQ-013: In IDLE, start=1 SHALL capture C_in into an internal buffer at that edge, load HEADER as the current byte, and enter START_BIT; busy=1 from the next cycle.
REQ-014: start while busy=1 SHALL be ignored; the buffer SHALL NOT change during a frame.
REQ-015: Frame order: HEADER, then element 0 .. ELEMS-1; each element sent as DATAWIDTH/8 bytes, least-significant byte first.
REQ-016: Each byte: tx=0 for CLKS_PER_BIT cycles, 8 data bits LSB first for CLKS_PER_BIT cycles each, then tx=1 for CLKS_PER_BIT cycles.
REQ-017: A baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap; bit transitions occur only on wrap.
REQ-018: After a stop bit, if bytes remain, the next start bit SHALL begin on the immediately following cycle, with no idle gap.
REQ-019: After the last byte's stop bit, return to IDLE, pulse done=1 for exactly one cycle, busy=0 in that same cycle.
REQ-020: tx falls on the first cycle after start is accepted; frame duration tx-fall to done = (1+ELEMS*DATAWIDTH/8)*10*CLKS_PER_BIT cycles.
REQ-021: start asserted in the cycle done pulses (state IDLE) SHALL be accepted, giving back-to-back frames.
REQ-022: tx SHALL be registered and glitch-free; no combinational path from start or C_in to tx.
REQ-023: Byte and bit indices SHALL be sized to hold ELEMS*DATAWIDTH/8 and 8 without overflow.

Reset
REQ-024: rst=0 SHALL immediately force state IDLE, tx=1, busy=0, done=0, counters 0, buffer 0, independent of clk.
REQ-025: Reset mid-frame SHALL abort the frame with no done pulse; tx returns high immediately.
REQ-026: After rst deasserts, the first start SHALL be honoured no earlier than the first rising edge at which rst is sampled high.

Structure
REQ-027: A shared package SHALL hold the state enumeration, the default HEADER value and the default CLKS_PER_BIT.
REQ-028: Byte serialisation (start/data/stop timing, baud counter) SHALL be a sub-module uart_tx_byte with byte-valid/ready handshake; result_uart_tx sequences bytes into it.

Verification (CLKS_PER_BIT=4, DATAWIDTH=8, ELEMS=16)
REQ-029: C_in element j = j+1, start pulse -> bench UART sampler decodes A5,01,02..10 hex; done exactly 680 cycles after tx first falls.
REQ-030: start held high for 50 cycles -> exactly one frame, one done pulse; C_in changed mid-frame does not alter the decoded bytes.
REQ-031: rst pulsed low during element 5's data bits -> tx=1 and busy=0 asynchronously; no done; a new start yields a full, correct frame.
REQ-032: start asserted in the done cycle -> second frame's start bit begins the next cycle; both frames decode correctly.
REQ-033: DATAWIDTH=16, ELEMS=2, C_in={16'h1234,16'hABCD} -> decoded A5,CD,AB,34,12.
REQ-034: Idle check: no start for 1000 cycles after reset -> tx=1, busy=0, done=0 throughout.
